tlx_cmd_credit_mgr: RTL and testbench
=====================================

Name: tlx_cmd_credit_mgr

Overview:
- Sits directly downstream of the actag/pasid context stage, between its command output and the TLX command interface.
- Tracks TLX command credits and command-data credits from the initial credit values and the credit return pulses.
- Debits credits for every command the context stage issues.
- Drives tlx_afu_cmd_ready, which is the ready that feeds back into that stage's s2_ready.

Parameters:
CMD_CW, 5, width of command credit counter (initial credit is 4 bits; one bit headroom)
DATA_CW, 7, width of data credit counter (initial credit is 6 bits; one bit headroom)
DATA_RSV, 4, data credits that must remain after in-flight debits before ready asserts (max dl = 4 beats)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
tlx_afu_ready  in  1  TLX link up / credits valid
tlx_afu_cmd_initial_credit  in  4  initial command credits
tlx_afu_cmd_data_initial_credit  in  6  initial data credits
tlx_afu_cmd_credit  in  1  one-cycle pulse: return 1 command credit
tlx_afu_cmd_data_credit  in  1  one-cycle pulse: return 1 data credit
in_cmd_valid  in  1  command issued to TLX this cycle (context stage output valid)
in_cmd_opcode  in  8  opcode of issued command
in_cmd_dl  in  2  data length of issued command
tlx_afu_cmd_ready  out  1  upstream may launch one command into its output register this cycle
cmd_credit_cnt  out  CMD_CW  current command credits
data_credit_cnt  out  DATA_CW  current data credits
err_underflow  out  1  sticky: command issued with insufficient credits
err_overflow  out  1  sticky: return would exceed counter range
perf_stall_cnt  out  32  ready-low cycles in RUN (optional feature)

Behaviour:
- Reset: state IDLE; both counters 0; tlx_afu_cmd_ready=0; err_*=0; perf_stall_cnt=0.
- FSM:
  - IDLE -> LOAD when tlx_afu_ready=1.
  - LOAD (1 cycle): cmd_cnt <= initial_credit + cmd_credit pulse; data_cnt <= data_initial_credit + data_credit pulse. Then -> RUN.
  - RUN -> IDLE when tlx_afu_ready=0. On that transition both counters clear to 0; err flags are kept.
- Data debit for in_cmd_valid:
  - opcode 0x20 (DMA write): dl 01 -> 1, 10 -> 2, 11 -> 4, 00 -> 4 (reserved; debited conservatively).
  - opcode 0x30 (partial write): 1.
  - Any other opcode: 0.
  - Command debit is always 1.
- Counter update in RUN, each cycle: cnt_next = cnt + return_pulse - debit. Simultaneous return and debit net out in the same cycle.
- Underflow: if debit exceeds cnt + return, the counter clamps to 0 and err_underflow sets.
- Overflow: if the result exceeds counter max, the counter saturates and err_overflow sets.
- Commands or returns arriving in IDLE/LOAD are ignored. A return arriving in LOAD is added as stated above.
- Ready, combinational, evaluated in RUN only:
  - ready = (cmd_cnt - in_cmd_valid) >= 1 AND (data_cnt - data_debit) >= DATA_RSV.
  - The in-flight command is subtracted because upstream registers its command one cycle after seeing ready, and this block debits one cycle after that.
  - Returns in the current cycle are not counted toward ready, which keeps the path short.
  - ready=0 outside RUN.
- Latency: debit and return are visible on the count outputs one cycle after the event.
- Reset mid-operation: all state clears asynchronously; ready drops immediately.

Optional Feature:
- Macro CREDIT_MGR_PERF_EN.
- Defined: perf_stall_cnt increments every RUN cycle with ready=0. It saturates at 0xFFFFFFFF and clears on reset only.
- Undefined: perf_stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then tlx_afu_ready=1 with initial credits 8/32 -> LOAD for one cycle, RUN next; cmd_credit_cnt=8, data_credit_cnt=32, ready=1.
- Issue 8 reads back-to-back (opcode 0x10), no returns -> ready drops in the cycle the 8th command is valid; cnt reaches 0 with no err_underflow.
- Data credits 6, issue DMA write dl=10 -> data_cnt=4, ready stays 1. Then DMA write dl=01 -> data_cnt=3, ready=0 until one data return makes it 4.
- Return pulse coincident with a partial-write command at cmd=2/data=5 -> next cycle cmd=2, data=5 (net zero).
- Force in_cmd_valid with cmd_cnt=0 -> cnt stays 0 and err_underflow=1 sticky. Return pulses at max -> err_overflow=1 and cnt saturated.
- With CREDIT_MGR_PERF_EN: hold cmd credits at 0 for 10 RUN cycles -> perf_stall_cnt=10. Drop tlx_afu_ready -> IDLE, counters 0, ready=0, perf count held.

Source files
------------

// File: rtl/tlx_cmd_credit_mgr.sv
// TLX command/data credit tracker between the context stage and the TLX command port.
// Optional stall counter built when CREDIT_MGR_PERF_EN is defined; otherwise perf_stall_cnt is 0.
module tlx_cmd_credit_mgr #(
  parameter int CMD_CW   = 5,
  parameter int DATA_CW  = 7,
  parameter int DATA_RSV = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tlx_afu_ready,
  input  logic [3:0]         tlx_afu_cmd_initial_credit,
  input  logic [5:0]         tlx_afu_cmd_data_initial_credit,
  input  logic               tlx_afu_cmd_credit,
  input  logic               tlx_afu_cmd_data_credit,
  input  logic               in_cmd_valid,
  input  logic [7:0]         in_cmd_opcode,
  input  logic [1:0]         in_cmd_dl,
  output logic               tlx_afu_cmd_ready,
  output logic [CMD_CW-1:0]  cmd_credit_cnt,
  output logic [DATA_CW-1:0] data_credit_cnt,
  output logic               err_underflow,
  output logic               err_overflow,
  output logic [31:0]        perf_stall_cnt,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [DATA_CW:0] DATA_RSV_W = (DATA_CW+1)'(DATA_RSV);

  state_t             state_q, state_d;
  logic [CMD_CW-1:0]  cmd_cnt_q;
  logic [DATA_CW-1:0] data_cnt_q;
  logic               err_uf_q, err_of_q;
  logic [2:0]         data_debit;

  logic [CMD_CW:0]    cmd_sum, cmd_deb, cmd_res;
  logic [DATA_CW:0]   data_sum, data_deb, data_res;
  logic [CMD_CW-1:0]  cmd_next;
  logic [DATA_CW-1:0] data_next;
  logic               uf_now, of_now;
  logic               ready;

  // Data beats charged per issued command; reserved dl=00 is charged as the maximum.
  always_comb begin
    data_debit = 3'd0;
    if (in_cmd_valid) begin
      case (in_cmd_opcode)
        8'h20: begin
          case (in_cmd_dl)
            2'b01:   data_debit = 3'd1;
            2'b10:   data_debit = 3'd2;
            default: data_debit = 3'd4;
          endcase
        end
        8'h30:   data_debit = 3'd1;
        default: data_debit = 3'd0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (tlx_afu_ready) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (!tlx_afu_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One extra bit on each sum exposes both clamp conditions.
  always_comb begin
    cmd_sum   = {1'b0, cmd_cnt_q} + {{CMD_CW{1'b0}}, tlx_afu_cmd_credit};
    cmd_deb   = {{CMD_CW{1'b0}}, in_cmd_valid};
    cmd_res   = cmd_sum - cmd_deb;
    data_sum  = {1'b0, data_cnt_q} + {{DATA_CW{1'b0}}, tlx_afu_cmd_data_credit};
    data_deb  = {{(DATA_CW-2){1'b0}}, data_debit};
    data_res  = data_sum - data_deb;
    uf_now    = 1'b0;
    of_now    = 1'b0;
    cmd_next  = cmd_res[CMD_CW-1:0];
    data_next = data_res[DATA_CW-1:0];
    if (cmd_sum < cmd_deb) begin
      cmd_next = '0;
      uf_now   = 1'b1;
    end else if (cmd_res[CMD_CW]) begin
      cmd_next = '1;
      of_now   = 1'b1;
    end
    if (data_sum < data_deb) begin
      data_next = '0;
      uf_now    = 1'b1;
    end else if (data_res[DATA_CW]) begin
      data_next = '1;
      of_now    = 1'b1;
    end
  end

  // The command in flight this cycle is charged before granting the next launch; returns are not.
  assign ready = (state_q == ST_RUN) &&
                 (cmd_cnt_q > CMD_CW'(in_cmd_valid)) &&
                 ({1'b0, data_cnt_q} >= DATA_RSV_W + data_deb);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_cnt_q  <= '0;
      data_cnt_q <= '0;
      err_uf_q   <= 1'b0;
      err_of_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          cmd_cnt_q  <= {{(CMD_CW-4){1'b0}}, tlx_afu_cmd_initial_credit} +
                        {{(CMD_CW-1){1'b0}}, tlx_afu_cmd_credit};
          data_cnt_q <= {{(DATA_CW-6){1'b0}}, tlx_afu_cmd_data_initial_credit} +
                        {{(DATA_CW-1){1'b0}}, tlx_afu_cmd_data_credit};
        end
        ST_RUN: begin
          if (!tlx_afu_ready) begin
            cmd_cnt_q  <= '0;
            data_cnt_q <= '0;
          end else begin
            cmd_cnt_q  <= cmd_next;
            data_cnt_q <= data_next;
            if (uf_now) err_uf_q <= 1'b1;
            if (of_now) err_of_q <= 1'b1;
          end
        end
        default: begin
          cmd_cnt_q  <= cmd_cnt_q;
          data_cnt_q <= data_cnt_q;
        end
      endcase
    end
  end

`ifdef CREDIT_MGR_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) perf_q <= '0;
    else if ((state_q == ST_RUN) && !ready && (perf_q != 32'hFFFF_FFFF))
      perf_q <= perf_q + 32'd1;
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

  assign tlx_afu_cmd_ready = ready;
  assign cmd_credit_cnt    = cmd_cnt_q;
  assign data_credit_cnt   = data_cnt_q;
  assign err_underflow     = err_uf_q;
  assign err_overflow      = err_of_q;
  assign fsm_state         = state_q;

endmodule

// File: tb/tb_tlx_cmd_credit_mgr.sv
// Bench for tlx_cmd_credit_mgr: directed test-plan steps plus a random phase against an integer credit model.
// Stall-counter expectations follow CREDIT_MGR_PERF_EN.
module tb_tlx_cmd_credit_mgr;

  localparam int CMD_MAX  = 31;
  localparam int DATA_MAX = 127;
  localparam int RSV      = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tlx_afu_ready;
  logic [3:0]  tlx_afu_cmd_initial_credit;
  logic [5:0]  tlx_afu_cmd_data_initial_credit;
  logic        tlx_afu_cmd_credit;
  logic        tlx_afu_cmd_data_credit;
  logic        in_cmd_valid;
  logic [7:0]  in_cmd_opcode;
  logic [1:0]  in_cmd_dl;
  logic        tlx_afu_cmd_ready;
  logic [4:0]  cmd_credit_cnt;
  logic [6:0]  data_credit_cnt;
  logic        err_underflow;
  logic        err_overflow;
  logic [31:0] perf_stall_cnt;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 load, 2 run; counts are plain integers.
  int          m_state, m_cmd, m_data;
  bit          m_eu, m_eo;
  int unsigned m_perf;

  tlx_cmd_credit_mgr dut (
    .clk                             (clk),
    .resetn                          (resetn),
    .tlx_afu_ready                   (tlx_afu_ready),
    .tlx_afu_cmd_initial_credit      (tlx_afu_cmd_initial_credit),
    .tlx_afu_cmd_data_initial_credit (tlx_afu_cmd_data_initial_credit),
    .tlx_afu_cmd_credit              (tlx_afu_cmd_credit),
    .tlx_afu_cmd_data_credit         (tlx_afu_cmd_data_credit),
    .in_cmd_valid                    (in_cmd_valid),
    .in_cmd_opcode                   (in_cmd_opcode),
    .in_cmd_dl                       (in_cmd_dl),
    .tlx_afu_cmd_ready               (tlx_afu_cmd_ready),
    .cmd_credit_cnt                  (cmd_credit_cnt),
    .data_credit_cnt                 (data_credit_cnt),
    .err_underflow                   (err_underflow),
    .err_overflow                    (err_overflow),
    .perf_stall_cnt                  (perf_stall_cnt),
    .fsm_state                       (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int data_beats(input logic [7:0] op, input logic [1:0] dl);
    if (op == 8'h20) begin
      if (dl == 2'b01) return 1;
      if (dl == 2'b10) return 2;
      return 4;
    end
    if (op == 8'h30) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_perf();
`ifdef CREDIT_MGR_PERF_EN
    return m_perf;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_cmd = 0; m_data = 0; m_eu = 0; m_eo = 0; m_perf = 0;
  endtask

  // Drive one cycle of inputs, check at the falling edge, advance the model at the rising edge.
  task automatic step(input bit v, input logic [7:0] op, input logic [1:0] dl,
                      input bit cr, input bit dr, input bit afu);
    int deb, nc, nd;
    bit exp_rdy;
    in_cmd_valid = v; in_cmd_opcode = op; in_cmd_dl = dl;
    tlx_afu_cmd_credit = cr; tlx_afu_cmd_data_credit = dr; tlx_afu_ready = afu;
    @(negedge clk);
    deb = v ? data_beats(op, dl) : 0;
    exp_rdy = (m_state == 2) && (m_cmd - int'(v) >= 1) && (m_data - deb >= RSV);
    check("ready", {31'd0, tlx_afu_cmd_ready}, {31'd0, exp_rdy});
    check("cmd_cnt", {27'd0, cmd_credit_cnt}, m_cmd);
    check("data_cnt", {25'd0, data_credit_cnt}, m_data);
    check("err_underflow", {31'd0, err_underflow}, {31'd0, m_eu});
    check("err_overflow", {31'd0, err_overflow}, {31'd0, m_eo});
    check("state", {30'd0, fsm_state}, m_state);
    check("perf", perf_stall_cnt, exp_perf());
    if (m_state == 2 && !exp_rdy && m_perf != 32'hFFFF_FFFF) m_perf++;
    case (m_state)
      0: if (afu) m_state = 1;
      1: begin
        m_cmd   = int'(tlx_afu_cmd_initial_credit) + int'(cr);
        m_data  = int'(tlx_afu_cmd_data_initial_credit) + int'(dr);
        m_state = 2;
      end
      default: begin
        if (!afu) begin
          m_state = 0; m_cmd = 0; m_data = 0;
        end else begin
          nc = m_cmd + int'(cr) - int'(v);
          nd = m_data + int'(dr) - deb;
          if (nc < 0) begin nc = 0; m_eu = 1; end
          if (nc > CMD_MAX) begin nc = CMD_MAX; m_eo = 1; end
          if (nd < 0) begin nd = 0; m_eu = 1; end
          if (nd > DATA_MAX) begin nd = DATA_MAX; m_eo = 1; end
          m_cmd = nc; m_data = nd;
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle_now();
    in_cmd_valid = 0; tlx_afu_cmd_credit = 0; tlx_afu_cmd_data_credit = 0;
    #1;
  endtask

  task automatic reload(input logic [3:0] ci, input logic [5:0] di);
    tlx_afu_cmd_initial_credit = ci;
    tlx_afu_cmd_data_initial_credit = di;
    step(0, 8'h00, 2'b00, 0, 0, 0);
    step(0, 8'h00, 2'b00, 0, 0, 1);
    step(0, 8'h00, 2'b00, 0, 0, 1);
  endtask

  task automatic reset_release();
    tlx_afu_ready = 0;
    idle_now();
    @(negedge clk);
    resetn = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] op;
    resetn = 0; tlx_afu_ready = 0; in_cmd_valid = 0; in_cmd_opcode = 8'h00; in_cmd_dl = 2'b00;
    tlx_afu_cmd_credit = 0; tlx_afu_cmd_data_credit = 0;
    tlx_afu_cmd_initial_credit = 4'd0; tlx_afu_cmd_data_initial_credit = 6'd0;
    model_reset();
    #12;
    check("rst_ready", {31'd0, tlx_afu_cmd_ready}, 0);
    check("rst_cmd", {27'd0, cmd_credit_cnt}, 0);
    check("rst_data", {25'd0, data_credit_cnt}, 0);
    check("rst_err", {30'd0, err_underflow, err_overflow}, 0);
    check("rst_state", {30'd0, fsm_state}, 0);
    check("rst_perf", perf_stall_cnt, 0);
    reset_release();

    // Bring-up with 8/32 credits: one LOAD cycle, then RUN.
    tlx_afu_cmd_initial_credit = 4'd8; tlx_afu_cmd_data_initial_credit = 6'd32;
    step(0, 8'h00, 2'b00, 0, 0, 1);
    check("tp_load_state", {30'd0, fsm_state}, 1);
    step(0, 8'h00, 2'b00, 0, 0, 1);
    check("tp_run_state", {30'd0, fsm_state}, 2);
    check("tp_init_cmd", {27'd0, cmd_credit_cnt}, 8);
    check("tp_init_data", {25'd0, data_credit_cnt}, 32);
    check("tp_init_ready", {31'd0, tlx_afu_cmd_ready}, 1);

    // Eight back-to-back reads drain the command credits exactly.
    for (int i = 0; i < 8; i++) step(1, 8'h10, 2'b00, 0, 0, 1);
    idle_now();
    check("tp_reads_cmd", {27'd0, cmd_credit_cnt}, 0);
    check("tp_reads_uf", {31'd0, err_underflow}, 0);
    check("tp_reads_ready", {31'd0, tlx_afu_cmd_ready}, 0);

    // Data reserve threshold.
    reload(4'd8, 6'd6);
    step(1, 8'h20, 2'b10, 0, 0, 1);
    idle_now();
    check("tp_dl2_data", {25'd0, data_credit_cnt}, 4);
    check("tp_dl2_ready", {31'd0, tlx_afu_cmd_ready}, 1);
    step(1, 8'h20, 2'b01, 0, 0, 1);
    idle_now();
    check("tp_dl1_data", {25'd0, data_credit_cnt}, 3);
    check("tp_dl1_ready", {31'd0, tlx_afu_cmd_ready}, 0);
    step(0, 8'h00, 2'b00, 0, 1, 1);
    idle_now();
    check("tp_ret_data", {25'd0, data_credit_cnt}, 4);
    check("tp_ret_ready", {31'd0, tlx_afu_cmd_ready}, 1);

    // Coincident return and partial write net to zero.
    reload(4'd2, 6'd5);
    step(1, 8'h30, 2'b00, 1, 1, 1);
    idle_now();
    check("tp_net_cmd", {27'd0, cmd_credit_cnt}, 2);
    check("tp_net_data", {25'd0, data_credit_cnt}, 5);

    // Underflow clamps and sticks.
    reload(4'd0, 6'd10);
    step(1, 8'h10, 2'b00, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 2'b00, 0, 0, 1);
    idle_now();
    check("tp_uf_cmd", {27'd0, cmd_credit_cnt}, 0);
    check("tp_uf_flag", {31'd0, err_underflow}, 1);

    // Overflow saturates both counters.
    reload(4'd15, 6'd63);
    for (int i = 0; i < 65; i++) step(0, 8'h00, 2'b00, 1, 1, 1);
    idle_now();
    check("tp_of_cmd", {27'd0, cmd_credit_cnt}, CMD_MAX);
    check("tp_of_data", {25'd0, data_credit_cnt}, DATA_MAX);
    check("tp_of_flag", {31'd0, err_overflow}, 1);

    // Random traffic, including link drops and unready issues.
    reload(4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: op = 8'h10;
        1: op = 8'h20;
        2: op = 8'h30;
        default: op = 8'($urandom_range(0, 255));
      endcase
      if (i % 150 == 0) begin
        tlx_afu_cmd_initial_credit = 4'($urandom_range(0, 15));
        tlx_afu_cmd_data_initial_credit = 6'($urandom_range(0, 63));
      end
      step(bit'($urandom_range(0, 2) == 0), op, 2'($urandom_range(0, 3)),
           bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 39) != 0));
    end

    // Asynchronous reset in the middle of RUN.
    reload(4'd8, 6'd32);
    idle_now();
    check("ar_ready_before", {31'd0, tlx_afu_cmd_ready}, 1);
    resetn = 0;
    #1;
    check("ar_ready", {31'd0, tlx_afu_cmd_ready}, 0);
    check("ar_cmd", {27'd0, cmd_credit_cnt}, 0);
    check("ar_data", {25'd0, data_credit_cnt}, 0);
    check("ar_state", {30'd0, fsm_state}, 0);
    check("ar_err", {30'd0, err_underflow, err_overflow}, 0);
    check("ar_perf", perf_stall_cnt, 0);
    model_reset();
    reset_release();

    // Ten stalled RUN cycles with no command credits, then link drop.
    reload(4'd0, 6'd32);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 2'b00, 0, 0, 1);
    idle_now();
`ifdef CREDIT_MGR_PERF_EN
    check("tp_perf10", perf_stall_cnt, 10);
`else
    check("tp_perf10", perf_stall_cnt, 0);
`endif
    for (int i = 0; i < 4; i++) step(0, 8'h00, 2'b00, 0, 0, 0);
    idle_now();
    check("tp_drop_state", {30'd0, fsm_state}, 0);
    check("tp_drop_cmd", {27'd0, cmd_credit_cnt}, 0);
    check("tp_drop_data", {25'd0, data_credit_cnt}, 0);
    check("tp_drop_ready", {31'd0, tlx_afu_cmd_ready}, 0);
`ifdef CREDIT_MGR_PERF_EN
    check("tp_perf_held", perf_stall_cnt, 11);
`else
    check("tp_perf_held", perf_stall_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
